// File: rtl/pc_pkg.sv
// Shared constants and types for the program counter block.
package pc_pkg;

  localparam int unsigned          PC_WIDTH        = 32;
  localparam logic [PC_WIDTH-1:0]  PC_RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned          PC_INCREMENT    = 4;

  typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential step or branch target, modulo 2^WIDTH.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH     = PC_WIDTH,
  parameter int unsigned INCREMENT = PC_INCREMENT
) (
  input  logic [WIDTH-1:0] cur_pc,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_offset,
  output logic [WIDTH-1:0] next_pc_c
);

  // Two's-complement add covers backward branches; carry out is dropped.
  always_comb begin
    next_pc_c = cur_pc + WIDTH'(INCREMENT);
    if (branch_taken) begin
      next_pc_c = cur_pc + branch_offset;
    end
  end

endmodule

// File: rtl/pc.sv
// Program counter register with one-cycle next-PC update.
// Optional misalignment flag output enabled by macro PC_MISALIGN_CHECK_EN.
module pc
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH        = PC_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
  parameter int unsigned       INCREMENT    = PC_INCREMENT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_PC,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_offset,
`ifdef PC_MISALIGN_CHECK_EN
  output logic             pc_misaligned,
`endif
  output logic [WIDTH-1:0] output_PC
);

  logic [WIDTH-1:0] next_pc_c;

  pc_next_calc #(
    .WIDTH     (WIDTH),
    .INCREMENT (INCREMENT)
  ) u_next_calc (
    .cur_pc        (input_PC),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .next_pc_c     (next_pc_c)
  );

  // PC register; reset forces the vector immediately and overrides all inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      output_PC <= RESET_VECTOR;
    end else begin
      output_PC <= next_pc_c;
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  // Flag registered alongside the PC; the PC itself still takes the misaligned value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_misaligned <= 1'b0;
    end else begin
      pc_misaligned <= |next_pc_c[1:0];
    end
  end
`endif

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for pc: behavioural model plus directed and random stimulus.
// Misalignment checks are compiled in when PC_MISALIGN_CHECK_EN is defined.
module tb_pc;

  localparam int unsigned W  = 32;
  localparam logic [W-1:0] RV = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] input_PC = '0;
  logic         branch_taken = 1'b0;
  logic [W-1:0] branch_offset = '0;
  logic [W-1:0] output_PC;
`ifdef PC_MISALIGN_CHECK_EN
  logic         pc_misaligned;
  logic         exp_mis = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_pc = RV;

  pc dut (
    .clk           (clk),
    .reset         (reset),
    .input_PC      (input_PC),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
`ifdef PC_MISALIGN_CHECK_EN
    .pc_misaligned (pc_misaligned),
`endif
    .output_PC     (output_PC)
  );

  always #5 clk = ~clk;

  // Next PC from the rules: widen, add signed offset or the fixed step, keep low W bits.
  function automatic logic [W-1:0] model_next(input logic [W-1:0] p, input logic bt,
                                              input logic [W-1:0] off);
    logic [2*W-1:0] sum;
    if (bt) sum = {{W{1'b0}}, p} + {{W{off[W-1]}}, off};
    else    sum = {{W{1'b0}}, p} + (2*W)'(4);
    return sum[W-1:0];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: vector while reset is low, rule-based next PC on each edge otherwise.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_pc = RV;
`ifdef PC_MISALIGN_CHECK_EN
      exp_mis = 1'b0;
`endif
    end else begin
      exp_pc = model_next(input_PC, branch_taken, branch_offset);
`ifdef PC_MISALIGN_CHECK_EN
      exp_mis = (exp_pc % 4) != 0;
`endif
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    check("model_pc", output_PC, exp_pc);
`ifdef PC_MISALIGN_CHECK_EN
    check("model_mis", W'(pc_misaligned), W'(exp_mis));
`endif
  end

  initial begin
    // Pin the model against hand-computed values.
    check("pin_wrap", model_next(32'hFFFF_FFFC, 1'b0, 32'h1234_5678), 32'h0);
    check("pin_back", model_next(32'h40, 1'b1, 32'hFFFF_FFF0), 32'h30);

    // Output holds the vector during reset without any clock edge.
    #1;
    check("reset_async", output_PC, 32'h0);
    @(negedge clk);
    #2;
    reset = 1'b1;

    // Looped sequential fetch after reset release.
    input_PC = output_PC; branch_taken = 1'b0; branch_offset = 32'hDEAD_BEEF;
    step(); check("seq4", output_PC, 32'd4);
    input_PC = output_PC;
    step(); check("seq8", output_PC, 32'd8);
    input_PC = output_PC;
    step(); check("seq12", output_PC, 32'd12);
    input_PC = output_PC;
    step(); check("seq16", output_PC, 32'd16);

    // Forward branch then sequential.
    input_PC = 32'd16; branch_taken = 1'b1; branch_offset = 32'd16;
    step(); check("branch_fwd", output_PC, 32'd32);
    input_PC = 32'd32; branch_taken = 1'b0;
    step(); check("after_branch", output_PC, 32'd36);

    // Wrap-around and backward branch.
    input_PC = 32'hFFFF_FFFC; branch_taken = 1'b0;
    step(); check("wrap", output_PC, 32'h0);
    input_PC = 32'h40; branch_taken = 1'b1; branch_offset = 32'hFFFF_FFF0;
    step(); check("branch_back", output_PC, 32'h30);

    // Odd PC propagates through the adder.
    input_PC = 32'd3; branch_taken = 1'b0;
    step(); check("odd_pc", output_PC, 32'd7);

    // Mid-operation reset between edges dominates a pending branch.
    input_PC = 32'hFC; branch_taken = 1'b0;
    step(); check("pre_reset", output_PC, 32'h100);
    input_PC = 32'h500; branch_taken = 1'b1; branch_offset = 32'h40;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("reset_mid", output_PC, 32'h0);
    step(); check("reset_hold1", output_PC, 32'h0);
    step(); check("reset_hold2", output_PC, 32'h0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    step(); check("post_reset", output_PC, 32'h540);

`ifdef PC_MISALIGN_CHECK_EN
    input_PC = 32'd8; branch_taken = 1'b1; branch_offset = 32'd2;
    step();
    check("mis_pc", output_PC, 32'd10);
    check("mis_flag", W'(pc_misaligned), 32'd1);
    input_PC = 32'd12; branch_taken = 1'b0;
    step();
    check("mis_clear", W'(pc_misaligned), 32'd0);
`endif

    // Randomized traffic with occasional reset pulses and looped stretches.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 3) == 0) input_PC = output_PC;
      else                           input_PC = $urandom;
      branch_taken = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 2))
        0:       branch_offset = W'($signed($urandom_range(0, 64)) - 32);
        1:       branch_offset = $urandom;
        default: branch_offset = {$urandom_range(0, 1) == 1 ? 2'b11 : 2'b00, 30'($urandom)};
      endcase
      step();
    end

    reset = 1'b1;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc.md
PC -- requirements
Module: pc

Interface
- REQ-001: Parameter WIDTH, default 32, sets the bit width of every address/offset port.
- REQ-002: Parameter RESET_VECTOR, default 32'h0000_0000, is the value loaded into output_PC on reset.
- REQ-003: Parameter INCREMENT, default 4, is the sequential step added when no branch is taken.
- REQ-004: clk  input  1  the single clock; all state SHALL update on its rising edge.
- REQ-005: reset  input  1  asynchronous, active-low reset.
- REQ-006: input_PC  input  WIDTH  current PC value, fed back from output_PC by the surrounding logic.
- REQ-007: branch_taken  input  1  high selects the branch target for the next PC.
- REQ-008: branch_offset  input  WIDTH  two's-complement signed offset added to input_PC on a taken branch.
- REQ-009: output_PC  output  WIDTH  registered next-PC value.

Function
- REQ-010: On each rising clk edge with reset high, output_PC SHALL load input_PC + branch_offset when branch_taken=1.
- REQ-011: On each rising clk edge with reset high, output_PC SHALL load input_PC + INCREMENT when branch_taken=0.
- REQ-012: Latency SHALL be exactly one clock from input_PC/branch_taken/branch_offset to output_PC; there is no combinational path from inputs to output_PC.
- REQ-013: All arithmetic SHALL be modulo 2^WIDTH: carries out are discarded, wrap-around is silent, and there is no overflow flag.
- REQ-014: A negative branch_offset (MSB=1) SHALL produce a backward target via plain two's-complement addition.
- REQ-015: branch_offset SHALL be ignored in any cycle where branch_taken=0.
- REQ-016: The block SHALL have no internal state other than the output_PC register (plus the optional flag of REQ-022).
- REQ-017: The block SHALL impose no alignment restriction on input_PC; odd values propagate unchanged through the adder.

Reset
- REQ-018: While reset=0, output_PC SHALL equal RESET_VECTOR immediately, without waiting for a clk edge.
- REQ-019: Reset SHALL take priority over branch_taken and over every other input.
- REQ-020: Assertion of reset mid-operation SHALL discard the in-flight next-PC value; no partial update is permitted.
- REQ-021: After reset deasserts, the first rising clk edge SHALL perform a normal update from the current inputs.

Configuration
- REQ-022: With macro PC_MISALIGN_CHECK_EN defined, the block SHALL add an output pc_misaligned (1 bit, registered alongside output_PC), high when bits [1:0] of the computed next PC are nonzero and cleared to 0 on reset.
- REQ-023: When pc_misaligned asserts, output_PC SHALL still load the misaligned value unchanged.
- REQ-024: With PC_MISALIGN_CHECK_EN undefined, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
- REQ-025: Shared package pc_pkg SHALL hold the default WIDTH, RESET_VECTOR and INCREMENT constants and a typedef pc_t (logic [WIDTH-1:0]).
- REQ-026: Next-PC selection and addition SHALL live in a combinational sub-module pc_next_calc; pc instantiates it and registers its result.

Verification
- REQ-027: Hold reset=0, then release it with input_PC looped from output_PC and branch_taken=0 -> output_PC is 0 during reset, then follows the sequence 4, 8, 12, 16 on successive clk edges.
- REQ-028: Drive input_PC=16, branch_taken=1, branch_offset=16 -> output_PC=32 one clock later; with branch_taken=0 the following clock, input_PC=32 gives output_PC=36.
- REQ-029: Drive input_PC=32'hFFFF_FFFC, branch_taken=0 -> output_PC=0, with no flag or error raised.
- REQ-030: Drive input_PC=32'h40, branch_taken=1, branch_offset=32'hFFFF_FFF0 -> output_PC=32'h30.
- REQ-031: Drive output_PC=32'h100, then pull reset low between clk edges -> output_PC=0 immediately; it stays 0 while reset is low even with branch_taken=1.
- REQ-032: With PC_MISALIGN_CHECK_EN defined, drive input_PC=8, branch_taken=1, branch_offset=2 -> output_PC=10 and pc_misaligned=1; the next non-branch clock from input_PC=12 gives pc_misaligned=0.
